// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes a MIPS instruction plus register values into the
// 4-bit ALU Func code and operand pair, held in a one-entry valid/ready
// output stage. mult/multu run in an iterative shift-add sequencer that owns
// HI/LO.
// Optional feature macro: ALU_ISSUE_MFHILO_EN (decode mfhi/mflo as pass-In2 of HI/LO).
module alu_issue_ctrl #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      func,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [4:0]      dest,
    output logic            illegal,
    output logic            mul_busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int ITER  = XLEN / MUL_STEP;
    localparam int CNT_W = $clog2(ITER) + 1;

    localparam logic [3:0] F_AND  = 4'b0000;
    localparam logic [3:0] F_OR   = 4'b0001;
    localparam logic [3:0] F_ADD  = 4'b0010;
    localparam logic [3:0] F_XOR  = 4'b0011;
    localparam logic [3:0] F_PASS = 4'b0101;
    localparam logic [3:0] F_SLT  = 4'b0111;
    localparam logic [3:0] F_SUB  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    // instruction fields
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rt_idx;
    logic [4:0]      rd_idx;
    logic [15:0]     imm;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] imm_zext;
    logic            unused_rs_field;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign rt_idx   = instr[20:16];
    assign rd_idx   = instr[15:11];
    assign imm      = instr[15:0];
    assign imm_sext = {{(XLEN-16){imm[15]}}, imm};
    assign imm_zext = {{(XLEN-16){1'b0}}, imm};
    // The rs index selects rs_val upstream; the decoder itself never needs it.
    assign unused_rs_field = ^instr[25:21];

    // state
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              msigned_q, msigned_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        func_q, func_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic [4:0]        dest_q, dest_d;
    logic              illegal_q, illegal_d;

    // decode results
    logic [3:0]      dec_func;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [4:0]      dec_dest;
    logic            dec_illegal;
    logic            dec_mul;
    logic            dec_mul_signed;

    logic              in_ready_c;
    logic              accept;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] mul_result;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] pp [MUL_STEP];

    // Combinational instruction decode; anything unrecognised becomes a bubble.
    always_comb begin
        dec_func       = F_ADD;
        dec_a          = '0;
        dec_b          = '0;
        dec_dest       = '0;
        dec_illegal    = 1'b0;
        dec_mul        = 1'b0;
        dec_mul_signed = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100001: begin
                        dec_func = F_ADD; dec_a = rs_val; dec_b = rt_val; dec_dest = rd_idx;
                    end
                    6'b100010, 6'b100011: begin
                        dec_func = F_SUB; dec_a = rs_val; dec_b = rt_val; dec_dest = rd_idx;
                    end
                    6'b100100: begin
                        dec_func = F_AND; dec_a = rs_val; dec_b = rt_val; dec_dest = rd_idx;
                    end
                    6'b100101: begin
                        dec_func = F_OR; dec_a = rs_val; dec_b = rt_val; dec_dest = rd_idx;
                    end
                    6'b100110: begin
                        dec_func = F_XOR; dec_a = rs_val; dec_b = rt_val; dec_dest = rd_idx;
                    end
                    6'b101010, 6'b101011: begin
                        dec_func = F_SLT; dec_a = rs_val; dec_b = rt_val; dec_dest = rd_idx;
                    end
                    6'b011000: begin
                        dec_mul = 1'b1; dec_mul_signed = 1'b1;
                    end
                    6'b011001: begin
                        dec_mul = 1'b1;
                    end
`ifdef ALU_ISSUE_MFHILO_EN
                    6'b010000: begin
                        dec_func = F_PASS; dec_b = hi_q; dec_dest = rd_idx;
                    end
                    6'b010010: begin
                        dec_func = F_PASS; dec_b = lo_q; dec_dest = rd_idx;
                    end
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'b001000, 6'b001001, 6'b100011: begin
                dec_func = F_ADD; dec_a = rs_val; dec_b = imm_sext; dec_dest = rt_idx;
            end
            6'b101011: begin
                dec_func = F_ADD; dec_a = rs_val; dec_b = imm_sext;
            end
            6'b001010, 6'b001011: begin
                dec_func = F_SLT; dec_a = rs_val; dec_b = imm_sext; dec_dest = rt_idx;
            end
            6'b001100: begin
                dec_func = F_AND; dec_a = rs_val; dec_b = imm_zext; dec_dest = rt_idx;
            end
            6'b001101: begin
                dec_func = F_OR; dec_a = rs_val; dec_b = imm_zext; dec_dest = rt_idx;
            end
            6'b001110: begin
                dec_func = F_XOR; dec_a = rs_val; dec_b = imm_zext; dec_dest = rt_idx;
            end
            6'b001111: begin
                dec_func = F_PASS; dec_a = rs_val; dec_b = {imm, 16'h0000}; dec_dest = rt_idx;
            end
            6'b000100, 6'b000101: begin
                dec_func = F_SUB; dec_a = rs_val; dec_b = rt_val;
            end
            6'b000010: begin
                // j: bubble toward the ALU, nothing to write back
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Partial products for the multiplier bits retired this cycle.
    for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
        assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
    end

    // Accumulate this cycle's partial products and form the signed final result.
    always_comb begin
        step_acc = acc_q;
        for (int s = 0; s < MUL_STEP; s++) begin
            step_acc = step_acc + pp[s];
        end
        mul_result = neg_q ? (~step_acc + 1'b1) : step_acc;
    end

    // Operand magnitudes for signed multiply, taken from the latched raw values.
    always_comb begin
        mag_a = mcand_q[XLEN-1:0];
        mag_b = mplier_q;
        if (msigned_q && mcand_q[XLEN-1]) begin
            mag_a = ~mcand_q[XLEN-1:0] + 1'b1;
        end
        if (msigned_q && mplier_q[XLEN-1]) begin
            mag_b = ~mplier_q + 1'b1;
        end
    end

    assign in_ready_c = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready_c;

    // Next-state logic for the output stage and the multiply sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        msigned_d   = msigned_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = out_valid_q;
        func_d      = func_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        dest_d      = dest_q;
        illegal_d   = accept && dec_illegal;

        // One-entry output buffer: multiplies never occupy it.
        if (accept && !dec_mul) begin
            out_valid_d = 1'b1;
            func_d      = dec_func;
            op_a_d      = dec_a;
            op_b_d      = dec_b;
            dest_d      = dec_dest;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && dec_mul) begin
                    state_d   = S_LOAD;
                    mcand_d   = {{XLEN{1'b0}}, rs_val};
                    mplier_d  = rt_val;
                    msigned_d = dec_mul_signed;
                end
            end
            S_LOAD: begin
                neg_d    = msigned_q && (mcand_q[XLEN-1] ^ mplier_q[XLEN-1]);
                mcand_d  = {{XLEN{1'b0}}, mag_a};
                mplier_d = mag_b;
                acc_d    = '0;
                cnt_d    = CNT_W'(ITER - 1);
                state_d  = S_MUL;
            end
            S_MUL: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << MUL_STEP;
                mplier_d = mplier_q >> MUL_STEP;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    hi_d    = mul_result[2*XLEN-1:XLEN];
                    lo_d    = mul_result[XLEN-1:0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            msigned_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            func_q      <= F_ADD;
            op_a_q      <= '0;
            op_b_q      <= '0;
            dest_q      <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            msigned_q   <= msigned_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            func_q      <= func_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            dest_q      <= dest_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign func      = func_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign dest      = dest_q;
    assign illegal   = illegal_q;
    assign mul_busy  = (state_q != S_IDLE);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized stimulus for alu_issue_ctrl,
// checked every cycle against a transaction-level reference model.
module tb_alu_issue_ctrl;

    localparam int MUL_STEP = 1;
    localparam int MUL_CYC  = 32 / MUL_STEP + 1;   // busy cycles after the accepting edge

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  dest;
    logic        illegal;
    logic        mul_busy;
    logic [31:0] hi;
    logic [31:0] lo;

    alu_issue_ctrl #(.XLEN(32), .MUL_STEP(MUL_STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .func      (func),
        .op_a      (op_a),
        .op_b      (op_b),
        .dest      (dest),
        .illegal   (illegal),
        .mul_busy  (mul_busy),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        ill;
        logic        mul;
        logic        sgn;
    } dec_t;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic        m_ov;
    dec_t        m_ent;
    logic        m_ill;
    int          m_busy;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd);
        return {6'b000000, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] im);
        return {op, 5'd1, rt, im};
    endfunction

    // Expected ALU request for one instruction, straight from the instruction table.
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [31:0] h,
                                        input logic [31:0] l);
        dec_t d;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] im;
        logic [31:0] sx;
        logic [31:0] zx;
        op = ins[31:26];
        fn = ins[5:0];
        im = ins[15:0];
        sx = {{16{im[15]}}, im};
        zx = {16'h0000, im};
        d = '0;
        d.func = 4'd2;
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B}) begin
                d.a = rs; d.b = rt; d.dest = ins[15:11];
                case (fn)
                    6'h20, 6'h21: d.func = 4'd2;
                    6'h22, 6'h23: d.func = 4'd10;
                    6'h24:        d.func = 4'd0;
                    6'h25:        d.func = 4'd1;
                    6'h26:        d.func = 4'd3;
                    default:      d.func = 4'd7;
                endcase
            end else if (fn == 6'h18 || fn == 6'h19) begin
                d.mul = 1'b1;
                d.sgn = (fn == 6'h18);
`ifdef ALU_ISSUE_MFHILO_EN
            end else if (fn == 6'h10 || fn == 6'h12) begin
                d.func = 4'd5;
                d.b    = (fn == 6'h10) ? h : l;
                d.dest = ins[15:11];
`endif
            end else begin
                d.ill = 1'b1;
            end
        end else begin
            case (op)
                6'h08, 6'h09, 6'h23: begin d.func = 4'd2;  d.a = rs; d.b = sx; d.dest = ins[20:16]; end
                6'h2B:               begin d.func = 4'd2;  d.a = rs; d.b = sx; end
                6'h0A, 6'h0B:        begin d.func = 4'd7;  d.a = rs; d.b = sx; d.dest = ins[20:16]; end
                6'h0C:               begin d.func = 4'd0;  d.a = rs; d.b = zx; d.dest = ins[20:16]; end
                6'h0D:               begin d.func = 4'd1;  d.a = rs; d.b = zx; d.dest = ins[20:16]; end
                6'h0E:               begin d.func = 4'd3;  d.a = rs; d.b = zx; d.dest = ins[20:16]; end
                6'h0F:               begin d.func = 4'd5;  d.a = rs; d.b = {im, 16'h0000}; d.dest = ins[20:16]; end
                6'h04, 6'h05:        begin d.func = 4'd10; d.a = rs; d.b = rt; end
                6'h02:               begin end
                default:             d.ill = 1'b1;
            endcase
        end
        return d;
    endfunction

    // Compare every visible output against the model after a clock edge.
    task automatic check_outputs();
        check_val("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check_val("func", func, m_ent.func);
            check_val("op_a", op_a, m_ent.a);
            check_val("op_b", op_b, m_ent.b);
            check_val("dest", dest, m_ent.dest);
        end
        check_val("illegal", illegal, m_ill);
        check_val("mul_busy", mul_busy, m_busy > 0);
        check_val("hi", hi, m_hi);
        check_val("lo", lo, m_lo);
    endtask

    // One clock: drive inputs, advance the model across the edge, check outputs.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] rsv,
                         input logic [31:0] rtv, input logic ordy);
        dec_t d;
        logic exp_rdy;
        logic acc;
        in_valid  = iv;
        instr     = ins;
        rs_val    = rsv;
        rt_val    = rtv;
        out_ready = ordy;
        #1;
        exp_rdy = (m_busy == 0) && (!m_ov || ordy);
        check_val("in_ready", in_ready, exp_rdy);
        acc = iv && exp_rdy;
        d = ref_decode(ins, rsv, rtv, m_hi, m_lo);
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end
        m_ill = acc && d.ill;
        if (acc && d.mul) begin
            m_busy = MUL_CYC;
            if (d.sgn) m_pend = {{32{rsv[31]}}, rsv} * {{32{rtv[31]}}, rtv};
            else       m_pend = {32'h0, rsv} * {32'h0, rtv};
        end
        if (acc && !d.mul) begin
            m_ov  = 1'b1;
            m_ent = d;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        if (acc) begin
            $display("issue t=%0t instr=%08h rs=%08h rt=%08h mul=%0d ill=%0d", $time, ins, rsv, rtv, d.mul, d.ill);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    // Hold reset across an edge, check reset values, release on a falling edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_func", func, 4'b0010);
        check_val("rst_op_a", op_a, 32'h0);
        check_val("rst_op_b", op_b, 32'h0);
        check_val("rst_dest", dest, 5'd0);
        check_val("rst_illegal", illegal, 1'b0);
        check_val("rst_mul_busy", mul_busy, 1'b0);
        check_val("rst_hi", hi, 32'h0);
        check_val("rst_lo", lo, 32'h0);
        check_val("rst_in_ready", in_ready, 1'b1);
        m_ov = 1'b0; m_ent = '0; m_ill = 1'b0; m_busy = 0; m_hi = '0; m_lo = '0; m_pend = '0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset t=%0t", $time);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  code;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 30);
        case (k)
            0:  code = 6'h20;  1: code = 6'h21;  2: code = 6'h22;  3: code = 6'h23;
            4:  code = 6'h24;  5: code = 6'h25;  6: code = 6'h26;  7: code = 6'h2A;
            8:  code = 6'h2B;  9: code = 6'h18; 10: code = 6'h19; 11: code = 6'h10;
            12: code = 6'h12; 13: code = 6'h00;
            default: code = 6'h00;
        endcase
        if (k <= 13) return {6'h00, w[25:6], code};
        case (k)
            14: code = 6'h08; 15: code = 6'h09; 16: code = 6'h0A; 17: code = 6'h0B;
            18: code = 6'h0C; 19: code = 6'h0D; 20: code = 6'h0E; 21: code = 6'h0F;
            22: code = 6'h23; 23: code = 6'h2B; 24: code = 6'h04; 25: code = 6'h05;
            26: code = 6'h02; 27: code = 6'h03; 28: code = 6'h3F;
            default: code = 6'h08;
        endcase
        return {code, w[25:0]};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_val = '0; rt_val = '0;
        m_ov = 1'b0; m_ent = '0; m_ill = 1'b0; m_busy = 0; m_hi = '0; m_lo = '0; m_pend = '0;
        @(negedge clk);
        do_reset();

        // first add after reset emits Func 0010 on the next cycle
        cycle(1'b1, r_ins(6'h20, 5'd3), 32'd5, 32'd7, 1'b1);
        check_val("add_func", func, 4'b0010);

        // immediate extension forms
        cycle(1'b1, i_ins(6'h08, 5'd5, 16'hFFFF), 32'h10, 32'h0, 1'b1);
        check_val("addi_op_b", op_b, 32'hFFFF_FFFF);
        check_val("addi_op_a", op_a, 32'h10);
        check_val("addi_dest", dest, 5'd5);
        cycle(1'b1, i_ins(6'h0D, 5'd6, 16'hFFFF), 32'h10, 32'h0, 1'b1);
        check_val("ori_op_b", op_b, 32'h0000_FFFF);
        cycle(1'b1, i_ins(6'h0F, 5'd7, 16'h1234), 32'h0, 32'h0, 1'b1);
        check_val("lui_func", func, 4'b0101);
        check_val("lui_op_b", op_b, 32'h1234_0000);

        // sub stalled three cycles, then full-rate issue
        cycle(1'b1, r_ins(6'h22, 5'd4), 32'd9, 32'd4, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, r_ins(6'h24, 5'd8), 32'hF0, 32'h3C, 1'b0);
        check_val("stall_func", func, 4'b1010);
        for (int i = 0; i < 4; i++) cycle(1'b1, r_ins(6'h25, 5'(i + 1)), $urandom, $urandom, 1'b1);

        // signed and unsigned multiply of the same operands
        cycle(1'b1, r_ins(6'h18, 5'd0), 32'hFFFF_FFFE, 32'd3, 1'b1);
        idle_cycles(MUL_CYC);
        check_val("mult_hi", hi, 32'hFFFF_FFFF);
        check_val("mult_lo", lo, 32'hFFFF_FFFA);
        cycle(1'b1, r_ins(6'h19, 5'd0), 32'hFFFF_FFFE, 32'd3, 1'b1);
        idle_cycles(MUL_CYC);
        check_val("multu_hi", hi, 32'h0000_0002);
        check_val("multu_lo", lo, 32'hFFFF_FFFA);

        // edge-case products
        cycle(1'b1, r_ins(6'h18, 5'd0), 32'h8000_0000, 32'h8000_0000, 1'b1);
        idle_cycles(MUL_CYC);
        check_val("minmin_hi", hi, 32'h4000_0000);
        check_val("minmin_lo", lo, 32'h0);
        cycle(1'b1, r_ins(6'h19, 5'd0), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        idle_cycles(MUL_CYC);
        check_val("maxsq_hi", hi, 32'hFFFF_FFFE);
        check_val("maxsq_lo", lo, 32'h1);
        cycle(1'b1, r_ins(6'h18, 5'd0), 32'h0, 32'hFFFF_FFF0, 1'b1);
        idle_cycles(MUL_CYC);

        // undecodable word, then mfhi (legal or not depending on the build)
        cycle(1'b1, 32'hFC00_0000, 32'h1, 32'h2, 1'b1);
        check_val("bad_illegal", illegal, 1'b1);
        check_val("bad_op_a", op_a, 32'h0);
        cycle(1'b1, r_ins(6'h10, 5'd9), 32'h0, 32'h0, 1'b1);
        cycle(1'b1, r_ins(6'h12, 5'd10), 32'h0, 32'h0, 1'b1);

        // entry in flight followed by a multiply; younger instruction waits
        cycle(1'b1, r_ins(6'h26, 5'd11), 32'hAAAA_0000, 32'h0F0F_0F0F, 1'b1);
        cycle(1'b1, r_ins(6'h19, 5'd0), 32'd1234, 32'd5678, 1'b1);
        for (int i = 0; i < MUL_CYC + 2; i++)
            cycle(1'b1, r_ins(6'h21, 5'd12), 32'd1, 32'd2, ($urandom_range(0, 1) == 1));

        // reset in the middle of a multiply discards it
        cycle(1'b1, r_ins(6'h18, 5'd0), 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        idle_cycles(10);
        do_reset();
        cycle(1'b1, r_ins(6'h20, 5'd3), 32'd1, 32'd1, 1'b1);
        check_val("post_rst_func", func, 4'b0010);

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            cycle(($urandom_range(0, 3) != 0), rand_instr(), rand_op(), rand_op(),
                  ($urandom_range(0, 3) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
